fsk_zc_demod_frame: RTL and testbench
=====================================

// Module: fsk_zc_demod_frame
// PURPOSE
//  Parametrised zero-crossing FSK demodulator for the RX path. Counts sign changes of the ADC
//  stream over fixed bit windows, applies hysteresis and a threshold, frames FRAME_BITS data
//  bits behind a start bit, and presents the frame to the host with flag/mask/overrun interrupts.
//  Sits between the RX ADC interface and the host register block.
// PARAMETERS
//  ADC_W       8   ADC sample width, two's complement
//  SPB         32  samples (clocks) per bit window, >=2
//  FRAME_BITS  16  data bits per frame, >=1
//  ZC_THRESH   2   decoded bit = 1 when window crossing count <= ZC_THRESH, else 0
//  HYST        0   hysteresis magnitude, 0..2^(ADC_W-1)-1
//  START_VAL   0   decoded value that marks a start bit
// PORTS
//  G_CLK_RX     in   1           RX sample clock, one ADC sample per rising edge
//  reset_n      in   1           async active-low reset
//  ADC          in   ADC_W       signed sample
//  rx_enable    in   1           receiver enable (level)
//  int_mask     in   1           1 = int_flag drives int_rx_host
//  int_clear    in   1           1-cycle pulse: clears int_flag and overrun
//  data_out     out  FRAME_BITS  last complete frame, first received bit in MSB
//  data_valid   out  1           1-cycle pulse when data_out updates
//  int_flag     out  1           frame-ready flag (sticky)
//  overrun      out  1           frame completed while int_flag already set (sticky)
//  status_busy  out  1           1 while in RECV
//  int_rx_host  out  1           int_flag & int_mask (combinational)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, sign_q=0 (positive), counters 0.
//  Sign tracker: sign_q<=1 when ADC <= -HYST-(HYST==0?0:0) and ADC<0 with ADC<=-HYST;
//   sign_q<=0 when ADC>=HYST and ADC>=0; otherwise held. HYST=0 => sign_q = ADC MSB.
//  Crossing: sign_q_next != sign_q. zc_cnt width $clog2(SPB+1), saturates at SPB.
//  Window: samp_cnt 0..SPB-1, free-running while rx_enable=1; at samp_cnt==SPB-1 the bit is
//   decided from zc_cnt including that sample's crossing; zc_cnt and samp_cnt restart at 0
//   next cycle. sign_q is continuous across windows (first sample compares to prior window).
//  FSM:
//   IDLE: counters held at 0; rx_enable=1 -> HUNT (window starts next cycle).
//   HUNT: each decided bit; ==START_VAL -> RECV, bit_cnt=0; else stay.
//   RECV: decided bit shifted into shreg (LSB in, shift left); bit_cnt++;
//    on FRAME_BITS-th bit: data_out<=shreg_next, data_valid=1 same edge, int_flag<=1,
//    overrun<=1 if int_flag was already 1 and int_clear=0; -> HUNT.
//   Any state: rx_enable=0 -> IDLE next edge; partial frame discarded; data_out,
//    int_flag, overrun held.
//  Frame latency: data_out/data_valid asserted the edge after sample (SPB*(FRAME_BITS+1))-1
//   counted from the start-bit window's first sample.
//  int_clear with frame completion same cycle: completion wins, int_flag=1, overrun unchanged.
//  int_clear alone: int_flag<=0, overrun<=0 next edge. data_out never cleared except by reset.
//  reset_n asserted mid-frame: immediate return to reset values.
// TESTING
//  1. Defaults, FRAME_BITS=16: start (tone, period 8 -> 8 crossings) then 0xA5C3 bits
//     (1=DC +40, 0=tone) -> data_out=16'hA5C3, one data_valid pulse, int_flag=1.
//  2. int_mask=0 then 1 with int_flag=1 -> int_rx_host 0 then 1; int_clear -> flag 0.
//  3. Two frames without int_clear -> overrun=1, data_out = second frame.
//  4. HYST=10, DC +40 with +/-5 noise toggling MSB -> zc_cnt stays 0, bits decode 1.
//  5. rx_enable dropped at bit 7 of frame -> IDLE, no data_valid, data_out unchanged.
//  6. reset_n low mid-RECV -> all outputs 0 asynchronously; clean frame decodes after release.

Source files
------------

// File: rtl/fsk_zc_demod_frame.sv
// Zero-crossing FSK demodulator: per-window sign-change counting with hysteresis,
// start-bit hunting, frame assembly and host interrupt/overrun flags.
module fsk_zc_demod_frame #(
  parameter int ADC_W      = 8,
  parameter int SPB        = 32,
  parameter int FRAME_BITS = 16,
  parameter int ZC_THRESH  = 2,
  parameter int HYST       = 0,
  parameter int START_VAL  = 0
) (
  input  logic                    G_CLK_RX,
  input  logic                    reset_n,
  input  logic signed [ADC_W-1:0] ADC,
  input  logic                    rx_enable,
  input  logic                    int_mask,
  input  logic                    int_clear,
  output logic [FRAME_BITS-1:0]   data_out,
  output logic                    data_valid,
  output logic                    int_flag,
  output logic                    overrun,
  output logic                    status_busy,
  output logic                    int_rx_host
);

  localparam int ZW = $clog2(SPB + 1);
  localparam int SW = $clog2(SPB);
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [ZW-1:0]          ZC_MAX    = ZW'(SPB);
  localparam logic [SW-1:0]          SAMP_LAST = SW'(SPB - 1);
  localparam logic [BW-1:0]          BIT_LAST  = BW'(FRAME_BITS - 1);
  localparam logic signed [ADC_W-1:0] HYST_P   = ADC_W'(HYST);
  localparam logic signed [ADC_W-1:0] HYST_N   = -HYST_P;
  localparam logic                   START_BIT = 1'(START_VAL);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HUNT = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;

  // Sign only flips once the sample leaves the +/-HYST dead band on the other side.
  function automatic logic sign_next(input logic signed [ADC_W-1:0] s, input logic cur);
    if (s[ADC_W-1] && (s <= HYST_N)) return 1'b1;
    if (!s[ADC_W-1] && (s >= HYST_P)) return 1'b0;
    return cur;
  endfunction

  function automatic logic [ZW-1:0] zc_sat_inc(input logic [ZW-1:0] cnt, input logic inc);
    if (inc && (cnt != ZC_MAX)) return cnt + ZW'(1);
    return cnt;
  endfunction

  // Few crossings in a window means the DC ("mark") symbol.
  function automatic logic decide_bit(input logic [ZW-1:0] cnt);
    logic [31:0] c32;
    c32 = 32'(cnt);
    return (c32 <= 32'(ZC_THRESH));
  endfunction

  function automatic logic [FRAME_BITS-1:0] shift_in(input logic [FRAME_BITS-1:0] sr,
                                                     input logic b);
    logic [FRAME_BITS:0] w;
    w = {sr, b};
    return w[FRAME_BITS-1:0];
  endfunction

  logic [1:0]            state_q, state_d;
  logic                  sign_q, sign_d;
  logic [SW-1:0]         samp_q, samp_d;
  logic [ZW-1:0]         zc_q, zc_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  flag_q, flag_d;
  logic                  ovr_q, ovr_d;

  logic                  crossing;
  logic                  win_end;
  logic                  bit_val;
  logic                  frame_done;
  logic [ZW-1:0]         zc_inc;
  logic [FRAME_BITS-1:0] shreg_nx;

  always_comb begin
    sign_d   = sign_next(ADC, sign_q);
    crossing = (sign_d != sign_q);
    zc_inc   = zc_sat_inc(zc_q, crossing);
    win_end  = (samp_q == SAMP_LAST);
    bit_val  = decide_bit(zc_inc);
    shreg_nx = shift_in(shreg_q, bit_val);
  end

  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    zc_d       = zc_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    frame_done = 1'b0;

    if (!rx_enable) begin
      state_d = S_IDLE;
      samp_d  = '0;
      zc_d    = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_HUNT;
          samp_d  = '0;
          zc_d    = '0;
        end
        S_HUNT, S_RECV: begin
          if (win_end) begin
            samp_d = '0;
            zc_d   = '0;
          end else begin
            samp_d = samp_q + SW'(1);
            zc_d   = zc_inc;
          end
          if (state_q == S_HUNT) begin
            if (win_end && (bit_val == START_BIT)) begin
              state_d = S_RECV;
              bit_d   = '0;
              shreg_d = '0;
            end
          end else if (win_end) begin
            shreg_d = shreg_nx;
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
              frame_done = 1'b1;
              state_d    = S_HUNT;
              data_d     = shreg_nx;
              valid_d    = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A completing frame takes priority over a simultaneous host clear.
  always_comb begin
    flag_d = flag_q;
    ovr_d  = ovr_q;
    if (frame_done) begin
      flag_d = 1'b1;
      if (flag_q && !int_clear) ovr_d = 1'b1;
    end else if (int_clear) begin
      flag_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge G_CLK_RX or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      samp_q  <= '0;
      zc_q    <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      samp_q  <= samp_d;
      zc_q    <= zc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      flag_q  <= flag_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign int_flag    = flag_q;
  assign overrun     = ovr_q;
  assign status_busy = (state_q == S_RECV);
  assign int_rx_host = flag_q & int_mask;

endmodule

// File: tb/tb_fsk_zc_demod_frame.sv
// Directed bench for fsk_zc_demod_frame: table of frames plus hand-written
// sequences for abort, async reset and hysteresis.
module tb_fsk_zc_demod_frame;

  localparam int SPB = 32;

  logic               clk;
  logic               reset_n;
  logic signed [7:0]  adc;
  logic               rx_en, rx_en_h;
  logic               int_mask, int_clear;

  logic [15:0] dout, dout_h;
  logic        dv, dv_h, flag, flag_h, ovr, ovr_h, busy, busy_h, host, host_h;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;
  int vcnt_h   = 0;

  fsk_zc_demod_frame #(.ADC_W(8), .SPB(SPB), .FRAME_BITS(16), .ZC_THRESH(2),
                       .HYST(0), .START_VAL(0)) dut (
    .G_CLK_RX(clk), .reset_n(reset_n), .ADC(adc), .rx_enable(rx_en),
    .int_mask(int_mask), .int_clear(int_clear), .data_out(dout), .data_valid(dv),
    .int_flag(flag), .overrun(ovr), .status_busy(busy), .int_rx_host(host));

  fsk_zc_demod_frame #(.ADC_W(8), .SPB(SPB), .FRAME_BITS(16), .ZC_THRESH(2),
                       .HYST(10), .START_VAL(0)) dut_h (
    .G_CLK_RX(clk), .reset_n(reset_n), .ADC(adc), .rx_enable(rx_en_h),
    .int_mask(int_mask), .int_clear(int_clear), .data_out(dout_h), .data_valid(dv_h),
    .int_flag(flag_h), .overrun(ovr_h), .status_busy(busy_h), .int_rx_host(host_h));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dv === 1'b1) vcnt++;
    if (dv_h === 1'b1) vcnt_h++;
  end

  typedef struct {
    logic        pre_clr;
    logic        mask;
    logic        clr_last;
    logic [15:0] frame;
    logic [15:0] exp_dout;
    logic        exp_flag;
    logic        exp_ovr;
    logic        exp_host;
  } vec_t;

  vec_t vecs[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0 = tone of period 8, 1 = DC +40 (optionally with sub-hysteresis noise).
  function automatic logic signed [7:0] sample(input logic b, input int i, input logic noisy);
    if (!b) return ((i % 8) < 4) ? 8'sd40 : -8'sd40;
    if (noisy) begin
      case (i % 4)
        1, 3:    return -8'sd5;
        2:       return 8'sd5;
        default: return 8'sd40;
      endcase
    end
    return 8'sd40;
  endfunction

  task automatic send_bit(input logic b, input logic noisy, input logic clr_on_last);
    for (int i = 0; i < SPB; i++) begin
      adc = sample(b, i, noisy);
      if (clr_on_last && (i == SPB - 1)) int_clear = 1'b1;
      tick;
    end
  endtask

  // Enables the chosen receiver from IDLE, sends one DC preamble window, the start
  // bit and the first nbits of frame (MSB first). Returns #1 after the last edge.
  task automatic send_frame(input logic [15:0] frame, input int nbits,
                            input logic clr_last, input logic hy, input logic noisy);
    logic [15:0] f;
    f = frame;
    adc = 8'sd40;
    if (hy) rx_en_h = 1'b1;
    else rx_en = 1'b1;
    tick;
    send_bit(1'b1, 1'b0, 1'b0);
    if (!hy) check("busy_hunt", 32'(busy), 32'(0));
    send_bit(1'b0, 1'b0, 1'b0);
    if (!hy) check("busy_recv", 32'(busy), 32'(1));
    for (int b = 0; b < nbits; b++)
      send_bit(f[15-b], noisy, clr_last && (b == nbits - 1));
    int_clear = 1'b0;
  endtask

  initial begin
    int vbefore;
    reset_n = 1'b0; adc = '0; rx_en = 1'b0; rx_en_h = 1'b0;
    int_mask = 1'b1; int_clear = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'hA5C3, 16'hA5C3, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h3C5A, 16'h3C5A, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h8001, 16'h8001, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'h7E81, 16'h7E81, 1'b1, 1'b1, 1'b0};

    #23;
    check("rst_dout", 32'(dout), 32'(0));
    check("rst_valid", 32'(dv), 32'(0));
    check("rst_flag", 32'(flag), 32'(0));
    check("rst_ovr", 32'(ovr), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_host", 32'(host), 32'(0));
    reset_n = 1'b1;
    tick;

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].pre_clr) begin
        int_clear = 1'b1;
        tick;
        int_clear = 1'b0;
      end
      int_mask = vecs[v].mask;
      vbefore = vcnt;
      send_frame(vecs[v].frame, 16, vecs[v].clr_last, 1'b0, 1'b0);
      check($sformatf("v%0d_valid", v), 32'(dv), 32'(1));
      check($sformatf("v%0d_dout", v), 32'(dout), 32'(vecs[v].exp_dout));
      check($sformatf("v%0d_flag", v), 32'(flag), 32'(vecs[v].exp_flag));
      check($sformatf("v%0d_ovr", v), 32'(ovr), 32'(vecs[v].exp_ovr));
      check($sformatf("v%0d_host", v), 32'(host), 32'(vecs[v].exp_host));
      check($sformatf("v%0d_busy", v), 32'(busy), 32'(0));
      rx_en = 1'b0;
      tick;
      check($sformatf("v%0d_valid_low", v), 32'(dv), 32'(0));
      check($sformatf("v%0d_pulses", v), 32'(vcnt - vbefore), 32'(1));
    end

    // Mask gating and host clear.
    int_mask = 1'b0; #1;
    check("mask0_host", 32'(host), 32'(0));
    int_mask = 1'b1; #1;
    check("mask1_host", 32'(host), 32'(1));
    int_clear = 1'b1;
    tick;
    int_clear = 1'b0;
    check("clr_flag", 32'(flag), 32'(0));
    check("clr_ovr", 32'(ovr), 32'(0));
    check("clr_host", 32'(host), 32'(0));
    check("clr_dout_kept", 32'(dout), 32'(16'h7E81));

    // Sub-hysteresis noise on mark bits breaks decoding when HYST=0.
    send_frame(16'hF0F0, 16, 1'b0, 1'b0, 1'b1);
    check("noisy_h0_dout", 32'(dout), 32'(16'h0000));
    check("noisy_h0_flag", 32'(flag), 32'(1));
    check("noisy_h0_ovr", 32'(ovr), 32'(0));
    rx_en = 1'b0;
    tick;

    // Receiver disabled after 7 data bits: frame abandoned.
    vbefore = vcnt;
    send_frame(16'h1357, 7, 1'b0, 1'b0, 1'b0);
    rx_en = 1'b0;
    tick;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_dout", 32'(dout), 32'(16'h0000));
    repeat (3) tick;
    check("abort_pulses", 32'(vcnt - vbefore), 32'(0));
    check("abort_flag", 32'(flag), 32'(1));
    send_frame(16'h2468, 16, 1'b0, 1'b0, 1'b0);
    check("after_abort_dout", 32'(dout), 32'(16'h2468));
    check("after_abort_ovr", 32'(ovr), 32'(1));
    rx_en = 1'b0;
    tick;

    // Asynchronous reset in the middle of a frame.
    send_frame(16'hBEEF, 5, 1'b0, 1'b0, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    check("arst_dout", 32'(dout), 32'(0));
    check("arst_valid", 32'(dv), 32'(0));
    check("arst_flag", 32'(flag), 32'(0));
    check("arst_ovr", 32'(ovr), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_host", 32'(host), 32'(0));
    rx_en = 1'b0;
    #2 reset_n = 1'b1;
    tick;
    send_frame(16'hC0DE, 16, 1'b0, 1'b0, 1'b0);
    check("post_rst_dout", 32'(dout), 32'(16'hC0DE));
    check("post_rst_flag", 32'(flag), 32'(1));
    check("post_rst_ovr", 32'(ovr), 32'(0));
    check("post_rst_host", 32'(host), 32'(1));
    rx_en = 1'b0;
    tick;

    // Hysteresis instance rejects the same noise.
    send_frame(16'hFFFF, 16, 1'b0, 1'b1, 1'b1);
    check("hyst_valid", 32'(dv_h), 32'(1));
    check("hyst_dout1", 32'(dout_h), 32'(16'hFFFF));
    check("hyst_flag", 32'(flag_h), 32'(1));
    rx_en_h = 1'b0;
    tick;
    send_frame(16'h5A3C, 16, 1'b0, 1'b1, 1'b1);
    check("hyst_dout2", 32'(dout_h), 32'(16'h5A3C));
    check("hyst_ovr", 32'(ovr_h), 32'(1));
    rx_en_h = 1'b0;
    tick;
    check("hyst_pulses", 32'(vcnt_h), 32'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
